// File: rtl/target_cache_update_ctrl.sv
// Target cache update controller: queues resolved-branch target updates from two
// commit slots and drains them in commit order to the target cache write port.
// Optional macro TC_INIT_CLEAR_EN adds a 256-entry clear sweep after reset.
module target_cache_update_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_pc,
  input  logic [31:0] req0_target,
  input  logic [9:0]  req0_bhr,
  input  logic        req1_valid,
  input  logic [31:0] req1_pc,
  input  logic [31:0] req1_target,
  input  logic [9:0]  req1_bhr,
  output logic        req_ready,
  input  logic        flush,
  output logic        tc_update_en,
  output logic [31:0] tc_update_pc,
  output logic [31:0] tc_update_target,
  output logic [9:0]  tc_update_bhr,
  output logic        busy
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned BHR_W = 10;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef TC_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [PC_W-1:0]  r_pc_mem  [DEPTH];
  logic [PC_W-1:0]  r_tgt_mem [DEPTH];
  logic [BHR_W-1:0] r_bhr_mem [DEPTH];
  logic             w_pop;
  logic             w_push0;
  logic             w_push1;
  logic [AW-1:0]    w_wr1_ptr;

`ifdef TC_INIT_CLEAR_EN
  logic [7:0]       r_sweep;

  // Clear-sweep index, advances once per INIT cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sweep <= 8'd0;
    end else if (r_state == ST_INIT) begin
      r_sweep <= r_sweep + 8'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and port outputs; reset forces the quiescent output values
  always_comb begin
    w_state_nxt      = r_state;
    req_ready        = 1'b0;
    w_pop            = 1'b0;
    busy             = 1'b1;
    tc_update_en     = 1'b0;
    tc_update_pc     = r_pc_mem[r_head];
    tc_update_target = r_tgt_mem[r_head];
    tc_update_bhr    = r_bhr_mem[r_head];
    case (r_state)
      ST_INIT: begin
`ifdef TC_INIT_CLEAR_EN
        // PC=0 makes the cache index equal the BHR, so the sweep hits every entry
        tc_update_en     = 1'b1;
        tc_update_pc     = '0;
        tc_update_target = '0;
        tc_update_bhr    = {2'b00, r_sweep};
        if (r_sweep == 8'hFF) begin
          w_state_nxt = ST_RUN;
        end
`else
        w_state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        req_ready    = !flush && (r_count <= CW'(DEPTH - 2));
        w_pop        = !flush && (r_count != '0);
        tc_update_en = w_pop;
        busy         = (r_count != '0);
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
    if (!resetn) begin
      req_ready    = 1'b0;
      w_pop        = 1'b0;
      tc_update_en = 1'b0;
      busy         = 1'b1;
    end
  end

  assign w_push0   = req_ready && req0_valid;
  assign w_push1   = req_ready && req1_valid;
  // Slot 1 lands behind slot 0 only when slot 0 actually pushed
  assign w_wr1_ptr = r_tail + AW'(w_push0);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if ((r_state == ST_RUN) && flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push0) + AW'(w_push1);
      r_count <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_pc_mem[r_tail]  <= req0_pc;
      r_tgt_mem[r_tail] <= req0_target;
      r_bhr_mem[r_tail] <= req0_bhr;
    end
    if (w_push1) begin
      r_pc_mem[w_wr1_ptr]  <= req1_pc;
      r_tgt_mem[w_wr1_ptr] <= req1_target;
      r_bhr_mem[w_wr1_ptr] <= req1_bhr;
    end
  end

endmodule

// File: tb/tb_target_cache_update_ctrl.sv
// Self-checking bench for target_cache_update_ctrl: directed scenarios plus
// random traffic compared against a queue-based model of the update FIFO.
module tb_target_cache_update_ctrl;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [9:0]  bhr;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_pc = '0;
  logic [31:0] req0_target = '0;
  logic [9:0]  req0_bhr = '0;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_pc = '0;
  logic [31:0] req1_target = '0;
  logic [9:0]  req1_bhr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        tc_update_en;
  logic [31:0] tc_update_pc;
  logic [31:0] tc_update_target;
  logic [9:0]  tc_update_bhr;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  target_cache_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req0_valid       (req0_valid),
    .req0_pc          (req0_pc),
    .req0_target      (req0_target),
    .req0_bhr         (req0_bhr),
    .req1_valid       (req1_valid),
    .req1_pc          (req1_pc),
    .req1_target      (req1_target),
    .req1_bhr         (req1_bhr),
    .req_ready        (req_ready),
    .flush            (flush),
    .tc_update_en     (tc_update_en),
    .tc_update_pc     (tc_update_pc),
    .tc_update_target (tc_update_target),
    .tc_update_bhr    (tc_update_bhr),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic new_req();
    req0_pc     = $urandom;
    req0_target = $urandom;
    req0_bhr    = 10'($urandom);
    req1_pc     = $urandom;
    req1_target = $urandom;
    req1_bhr    = 10'($urandom);
    req0_valid  = 1'($urandom);
    req1_valid  = 1'($urandom);
  endtask

  // One RUN-mode cycle: check against the model, then advance the model.
  // Entered and left just after a falling edge.
  task automatic cycle(output bit acc);
    bit   exp_rdy;
    bit   exp_en;
    ent_t e;
    #1;
    exp_rdy = (q.size() <= int'(DEPTH) - 2) && !flush;
    exp_en  = (q.size() != 0) && !flush;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tc_update_en", 32'(tc_update_en), 32'(exp_en));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (exp_en) begin
      chk("tc_update_pc", tc_update_pc, q[0].pc);
      chk("tc_update_target", tc_update_target, q[0].tgt);
      chk("tc_update_bhr", 32'(tc_update_bhr), 32'(q[0].bhr));
    end
    @(posedge clk);
    if (exp_en) void'(q.pop_front());
    if (exp_rdy && req0_valid) begin
      e.pc = req0_pc; e.tgt = req0_target; e.bhr = req0_bhr;
      q.push_back(e);
    end
    if (exp_rdy && req1_valid) begin
      e.pc = req1_pc; e.tgt = req1_target; e.bhr = req1_bhr;
      q.push_back(e);
    end
    if (flush) q.delete();
    acc = exp_rdy;
    @(negedge clk);
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("sweep_en", 32'(tc_update_en), 32'd1);
      chk("sweep_bhr", 32'(tc_update_bhr), 32'(i));
      chk("sweep_pc", tc_update_pc, 32'd0);
      chk("sweep_target", tc_update_target, 32'd0);
      chk("sweep_ready", 32'(req_ready), 32'd0);
      chk("sweep_busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    idle();
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_en", 32'(tc_update_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    q.delete();
    resetn = 1'b1;
`ifdef TC_INIT_CLEAR_EN
    sweep(256);
`endif
  endtask

  initial begin
    bit acc;
    int sent;
    @(negedge clk);
    do_reset(3);

`ifdef TC_INIT_CLEAR_EN
    // Reset in the middle of the clear sweep restarts it from index 0
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sweep(100);
    do_reset(1);
`endif

    // Two slots into an empty FIFO drain on consecutive cycles
    req0_valid = 1'b1; req0_pc = 32'h1000; req0_target = 32'h2000; req0_bhr = 10'h3;
    req1_valid = 1'b1; req1_pc = 32'h1010; req1_target = 32'h3000; req1_bhr = 10'h4;
    cycle(acc);
    idle();
    repeat (3) cycle(acc);

    // Only slot 1 valid produces exactly one entry
    req0_valid = 1'b0; req0_pc = 32'hDEAD;
    req1_valid = 1'b1; req1_pc = 32'h5550; req1_target = 32'h6660; req1_bhr = 10'h2AA;
    cycle(acc);
    idle();
    repeat (3) cycle(acc);

    // Both slots every cycle: back-pressure, then full drain in order
    sent = 0;
    new_req();
    while (sent < 20) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cycle(acc);
      if (acc) begin
        sent += 2;
        new_req();
      end
    end
    idle();
    repeat (5) cycle(acc);

    // Three entries queued, then a one-cycle flush
    new_req(); req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(acc);
    new_req(); req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(acc);
    idle();
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    repeat (3) cycle(acc);

    // Random traffic; unaccepted requests are held unchanged
    acc = 1'b1;
    repeat (400) begin
      if (acc) new_req();
      flush = ($urandom_range(15) == 0);
      cycle(acc);
    end
    idle();
    repeat (4) cycle(acc);

    // Reset with a non-empty FIFO discards everything
    new_req(); req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(acc);
    do_reset(2);
    repeat (4) cycle(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/target_cache_update_ctrl.md
TARGET_CACHE_UPDATE_CTRL -- requirements
Module: target_cache_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the update FIFO depth in entries; legal values are powers of two, 4 or greater.
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  SHALL be the synchronous, active-low reset.
REQ-004 req0_valid  input  1  SHALL indicate a resolved-branch target update on commit slot 0.
REQ-005 req0_pc / req0_target / req0_bhr  input  32/32/10  SHALL carry the branch PC, the resolved target and the BHR for slot 0.
REQ-006 req1_valid, req1_pc, req1_target, req1_bhr  input  1/32/32/10  SHALL carry the same fields for commit slot 1 (younger than slot 0).
REQ-007 req_ready  output  1  SHALL be the common accept indication for both slots.
REQ-008 flush  input  1  SHALL discard all queued updates.
REQ-009 tc_update_en  output  1  SHALL be the write strobe to the target cache update port.
REQ-010 tc_update_pc / tc_update_target / tc_update_bhr  output  32/32/10  SHALL be the write PC, data and BHR for that port.
REQ-011 busy  output  1  SHALL be high when the block is in INIT or the FIFO is non-empty.

Function
REQ-012 The block SHALL implement states INIT and RUN.
REQ-013 req_ready SHALL be high only when state=RUN, at least 2 FIFO slots are free (count <= DEPTH-2, using the current-cycle count), and flush=0.
REQ-014 When req_ready=1, each valid slot SHALL be pushed that cycle, slot 0 before slot 1; 0, 1 or 2 entries SHALL be pushed per cycle, and invalid slots SHALL create no entry.
REQ-015 When req_ready=0, both requests SHALL be ignored; requesters SHALL hold them.
REQ-016 In RUN with count>0 and flush=0, tc_update_en SHALL be 1 and the tc_update_* outputs SHALL equal the head entry combinationally; the head SHALL be popped that cycle.
REQ-017 Push and pop in the same cycle SHALL be legal; next count SHALL equal count + pushes - pop.
REQ-018 An entry pushed in cycle N SHALL appear at the port no earlier than cycle N+1. Latency to an empty FIFO SHALL be exactly 1 cycle.
REQ-019 Entries SHALL be written in strict commit order.
REQ-020 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-021 flush=1 in RUN SHALL:
  - set count, head and tail to 0 at the next edge;
  - force tc_update_en=0 that cycle;
  - accept no push that cycle.
REQ-022 flush SHALL be ignored in INIT.
REQ-023 With no pending update in RUN, tc_update_en SHALL be 0 and the tc_update_* data outputs SHALL be don't-care.

Reset
REQ-024 resetn=0 at a clock edge SHALL:
  - set state=INIT (or RUN, see REQ-027);
  - set the sweep counter, count, head and tail to 0.
REQ-025 While resetn=0, the outputs SHALL be tc_update_en=0, req_ready=0 and busy=1.
REQ-026 Reset asserted mid-sweep or with the FIFO non-empty SHALL abandon all progress; the sweep SHALL restart at index 0 after release.

Configuration
REQ-027 Macro TC_INIT_CLEAR_EN defined: INIT SHALL run for 256 cycles after reset release, as follows.
  - Sweep i = 0..255 drives tc_update_en=1, tc_update_pc=0, tc_update_target=0 and tc_update_bhr={2'b00, i[7:0]}.
  - With PC=0, the cache index equals i, so every entry is cleared.
  - After i=255 the state becomes RUN.
  - req_ready=0 throughout.
REQ-028 Macro TC_INIT_CLEAR_EN undefined: reset SHALL enter RUN directly, with no sweep logic and no clear writes; busy SHALL be low after reset with an empty FIFO.

Verification
REQ-029 With TC_INIT_CLEAR_EN, release reset -> 256 consecutive writes with bhr 0x000..0x0FF and target 0, then req_ready=1 on the next cycle.
REQ-030 Empty FIFO, req0 (pc 0x1000, target 0x2000, bhr 0x3) and req1 (pc 0x1010, target 0x3000, bhr 0x4) both valid in cycle N -> 0x1000/0x2000 written in N+1, 0x1010/0x3000 in N+2.
REQ-031 DEPTH=4, both slots valid every cycle -> req_ready drops once count reaches 3. The port writes every cycle with no loss and no reordering across 20 requests.
REQ-032 Three entries queued, flush=1 for one cycle -> tc_update_en=0 that cycle; next cycle count=0, busy=0 and no stale write follows.
REQ-033 Assert resetn=0 at sweep index 100 for one cycle -> the sweep restarts at bhr 0x000 and completes all 256 writes.
REQ-034 Only req1_valid=1 (req0 invalid) -> exactly one entry pushed, carrying the req1 fields.
